// File: rtl/eq_error_detector_pkg.sv
`default_nettype none
// ============================================================================
// Module  : eq_err_pkg
// Purpose : Shared types and width helpers for the equalizer decision and
//           error-sign stage (eq_error_detector / round_sat).
// Ports   : none (package)
// Revision: 1.0 - initial release
// ============================================================================
package eq_err_pkg;

  // Lock-detect state: acquiring or tracking.
  typedef enum logic [0:0] {
    ST_ACQ   = 1'b0,
    ST_TRACK = 1'b1
  } eq_lock_state_t;

  // Default geometry of the block.
  localparam int unsigned EQ_DEF_DATA_WIDTH = 36;
  localparam int unsigned EQ_DEF_PHASE_NUM  = 2;
  localparam int unsigned EQ_DEF_OUT_WIDTH  = 16;
  localparam int unsigned EQ_DEF_SHIFT      = 18;
  localparam int unsigned EQ_DEF_WIN_LOG2   = 10;

  // Width of the shifted/rounded value before saturation. One extra bit
  // covers the carry from adding the rounding constant.
  function automatic int rnd_width(input int dw, input int sh);
    return dw - sh + 1;
  endfunction

  // Slicer error width: d - y never overflows at OUT_WIDTH+2 bits.
  function automatic int err_width(input int ow);
    return ow + 2;
  endfunction

  // Phase-select width, kept at least 1 bit for single-phase builds.
  function automatic int sel_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/eq_error_detector_round_sat.sv
`default_nettype none
// ============================================================================
// Module  : round_sat
// Purpose : Two registered stages: arithmetic right shift with round-half-up,
//           then symmetric saturation to +/-(2^(OUT_WIDTH-1)-1).
// Ports   : clk, reset (async, active-high)
//           ce_i   - input sample valid / clock enable of stage 1
//           x_i    - signed full-precision sample
//           y_o    - signed rounded and saturated sample
//           vld_o  - y_o carries a new sample this cycle
// Revision: 1.0 - initial release
// ============================================================================
module round_sat
  import eq_err_pkg::*;
#(
  parameter int DATA_WIDTH = 36,
  parameter int OUT_WIDTH  = 16,
  parameter int SHIFT      = 18
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        ce_i,
  input  logic signed [DATA_WIDTH-1:0] x_i,
  output logic signed [OUT_WIDTH-1:0]  y_o,
  output logic                        vld_o
);

  // Assumes DATA_WIDTH-SHIFT+1 >= OUT_WIDTH, i.e. saturation can be needed.
  localparam int RW = rnd_width(DATA_WIDTH, SHIFT);
  localparam logic signed [DATA_WIDTH:0] HALF    = (DATA_WIDTH+1)'(1) << (SHIFT-1);
  localparam logic signed [RW-1:0]       SAT_MAX = RW'((1 << (OUT_WIDTH-1)) - 1);
  localparam logic signed [RW-1:0]       SAT_MIN = -SAT_MAX;

  logic signed [DATA_WIDTH:0] w_x_ext;
  logic signed [RW-1:0]       w_rnd;
  logic signed [OUT_WIDTH-1:0] w_sat;

  logic signed [RW-1:0]        rnd_q;
  logic signed [OUT_WIDTH-1:0] y_q;
  logic                        vld1_q;
  logic                        vld2_q;

  // Sign-extend by one bit so x + 2^(SHIFT-1) cannot wrap at full scale.
  always_comb begin
    w_x_ext = {x_i[DATA_WIDTH-1], x_i};
    w_rnd   = RW'((w_x_ext + HALF) >>> SHIFT);
  end

  always_comb begin
    if (rnd_q > SAT_MAX) begin
      w_sat = SAT_MAX[OUT_WIDTH-1:0];
    end else if (rnd_q < SAT_MIN) begin
      w_sat = SAT_MIN[OUT_WIDTH-1:0];
    end else begin
      w_sat = rnd_q[OUT_WIDTH-1:0];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rnd_q  <= '0;
      y_q    <= '0;
      vld1_q <= 1'b0;
      vld2_q <= 1'b0;
    end else begin
      vld1_q <= ce_i;
      vld2_q <= vld1_q;
      if (ce_i) begin
        rnd_q <= w_rnd;
      end
      if (vld1_q) begin
        y_q <= w_sat;
      end
    end
  end

  assign y_o   = y_q;
  assign vld_o = vld2_q;

endmodule
`default_nettype wire

// File: rtl/eq_error_detector.sv
`default_nettype none
// ============================================================================
// Module  : eq_error_detector
// Purpose : Symbol decision and error-sign stage behind the LMS equalizer.
//           Selects the symbol phase, rounds/saturates, slices against +/-R,
//           emits error sign + symbol strobe, and tracks lock per window.
// Ports   : clk, reset (async, active-high)
//           i_dtin       - multi-phase equalizer output
//           i_vldin      - input beat valid
//           i_sym_phase  - phase carrying the symbol
//           i_ref_level  - decision amplitude R (unsigned, > 0)
//           i_lock_thr   - big-error count at/below which lock is declared
//           i_unlock_thr - big-error count at/above which lock is lost
//           o_dout       - rounded, saturated symbol
//           o_sym_vld    - one-cycle strobe per symbol
//           o_error      - error sign (1 when d - y < 0)
//           o_lock       - high while tracking
//           o_err_cnt    - big-error count of last completed window
// Revision: 1.0 - initial release
// ============================================================================
module eq_error_detector
  import eq_err_pkg::*;
#(
  parameter  int _DATA_WIDTH = 36,
  parameter  int _PHASE_NUM  = 2,
  parameter  int _OUT_WIDTH  = 16,
  parameter  int _SHIFT      = 18,
  parameter  int _WIN_LOG2   = 10,
  localparam int SPW         = sel_width(_PHASE_NUM)
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [_DATA_WIDTH*_PHASE_NUM-1:0] i_dtin,
  input  logic                              i_vldin,
  input  logic [SPW-1:0]                    i_sym_phase,
  input  logic [_OUT_WIDTH-1:0]             i_ref_level,
  input  logic [_WIN_LOG2:0]                i_lock_thr,
  input  logic [_WIN_LOG2:0]                i_unlock_thr,
  output logic [_OUT_WIDTH-1:0]             o_dout,
  output logic                              o_sym_vld,
  output logic                              o_error,
  output logic                              o_lock,
  output logic [_WIN_LOG2:0]                o_err_cnt
);

  localparam int EW = err_width(_OUT_WIDTH);
  localparam logic [_WIN_LOG2:0] CNT_MAX = {1'b1, {_WIN_LOG2{1'b0}}};

  logic signed [_DATA_WIDTH-1:0] w_sel;
  logic signed [_OUT_WIDTH-1:0]  w_y;
  logic                          w_y_vld;
  logic signed [EW-1:0]          w_y_ext;
  logic signed [EW-1:0]          w_r_ext;
  logic signed [EW-1:0]          w_dec;
  logic signed [EW-1:0]          w_e;
  logic        [EW-1:0]          w_abs_e;
  logic        [EW-1:0]          w_half;
  logic                          w_big;

  logic [_OUT_WIDTH-1:0] dout_q;
  logic                  sym_vld_q;
  logic                  error_q;
  logic                  big_q;

  logic [_WIN_LOG2-1:0] win_q, win_d;
  logic [_WIN_LOG2:0]   big_cnt_q, big_cnt_d;
  logic [_WIN_LOG2:0]   err_cnt_q, err_cnt_d;
  logic [_WIN_LOG2:0]   w_cnt_incl;
  logic                 w_win_end;
  eq_lock_state_t       state_q, state_d;

  // Phase mux; out-of-range indices fall back to phase 0.
  always_comb begin
    w_sel = i_dtin[_DATA_WIDTH-1:0];
    for (int k = 1; k < _PHASE_NUM; k++) begin
      if (i_sym_phase == SPW'(k)) begin
        w_sel = i_dtin[k*_DATA_WIDTH +: _DATA_WIDTH];
      end
    end
  end

  round_sat #(
    .DATA_WIDTH (_DATA_WIDTH),
    .OUT_WIDTH  (_OUT_WIDTH),
    .SHIFT      (_SHIFT)
  ) u_round_sat (
    .clk   (clk),
    .reset (reset),
    .ce_i  (i_vldin),
    .x_i   (w_sel),
    .y_o   (w_y),
    .vld_o (w_y_vld)
  );

  // Slicer: y = 0 decides +R. |e| <= R + max|y| fits EW bits unsigned.
  always_comb begin
    w_y_ext = {{2{w_y[_OUT_WIDTH-1]}}, w_y};
    w_r_ext = {2'b00, i_ref_level};
    w_dec   = w_y[_OUT_WIDTH-1] ? -w_r_ext : w_r_ext;
    w_e     = w_dec - w_y_ext;
    w_abs_e = w_e[EW-1] ? $unsigned(-w_e) : $unsigned(w_e);
    w_half  = {3'b000, i_ref_level[_OUT_WIDTH-1:1]};
    w_big   = (w_abs_e > w_half);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dout_q    <= '0;
      sym_vld_q <= 1'b0;
      error_q   <= 1'b0;
      big_q     <= 1'b0;
    end else begin
      sym_vld_q <= w_y_vld;
      if (w_y_vld) begin
        dout_q  <= w_y;
        error_q <= w_e[EW-1];
        big_q   <= w_big;
      end
    end
  end

  // Window bookkeeping runs on the output strobe, so window results land
  // one cycle after the last symbol of the window leaves the pipeline.
  always_comb begin
    win_d      = win_q;
    big_cnt_d  = big_cnt_q;
    err_cnt_d  = err_cnt_q;
    w_cnt_incl = big_cnt_q;
    if (sym_vld_q && big_q && (big_cnt_q != CNT_MAX)) begin
      w_cnt_incl = big_cnt_q + 1'b1;
    end
    w_win_end = sym_vld_q && (win_q == '1);
    if (sym_vld_q) begin
      win_d = win_q + 1'b1;
      if (w_win_end) begin
        big_cnt_d = '0;
        err_cnt_d = w_cnt_incl;
      end else begin
        big_cnt_d = w_cnt_incl;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    if (w_win_end) begin
      case (state_q)
        ST_ACQ:   if (w_cnt_incl <= i_lock_thr)   state_d = ST_TRACK;
        ST_TRACK: if (w_cnt_incl >= i_unlock_thr) state_d = ST_ACQ;
        default:  state_d = ST_ACQ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      win_q     <= '0;
      big_cnt_q <= '0;
      err_cnt_q <= '0;
      state_q   <= ST_ACQ;
    end else begin
      win_q     <= win_d;
      big_cnt_q <= big_cnt_d;
      err_cnt_q <= err_cnt_d;
      state_q   <= state_d;
    end
  end

  assign o_dout    = dout_q;
  assign o_sym_vld = sym_vld_q;
  assign o_error   = error_q;
  assign o_lock    = (state_q == ST_TRACK);
  assign o_err_cnt = err_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_eq_error_detector.sv
`default_nettype none
// ============================================================================
// Module  : tb_eq_error_detector
// Purpose : Self-checking bench for eq_error_detector: table of single-symbol
//           vectors plus sequences for phase switching, gapped valids, lock
//           windows and asynchronous reset mid-window.
// Revision: 1.0 - initial release
// ============================================================================
module tb_eq_error_detector;

  localparam int DW = 36;
  localparam int PN = 2;
  localparam int OW = 16;
  localparam int SH = 18;
  localparam int WL = 10;

  logic              clk = 1'b0;
  logic              reset;
  logic [DW*PN-1:0]  i_dtin;
  logic              i_vldin;
  logic [0:0]        i_sym_phase;
  logic [OW-1:0]     i_ref_level;
  logic [WL:0]       i_lock_thr;
  logic [WL:0]       i_unlock_thr;
  logic [OW-1:0]     o_dout;
  logic              o_sym_vld;
  logic              o_error;
  logic              o_lock;
  logic [WL:0]       o_err_cnt;

  eq_error_detector #(
    ._DATA_WIDTH (DW),
    ._PHASE_NUM  (PN),
    ._OUT_WIDTH  (OW),
    ._SHIFT      (SH),
    ._WIN_LOG2   (WL)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .i_dtin       (i_dtin),
    .i_vldin      (i_vldin),
    .i_sym_phase  (i_sym_phase),
    .i_ref_level  (i_ref_level),
    .i_lock_thr   (i_lock_thr),
    .i_unlock_thr (i_unlock_thr),
    .o_dout       (o_dout),
    .o_sym_vld    (o_sym_vld),
    .o_error      (o_error),
    .o_lock       (o_lock),
    .o_err_cnt    (o_err_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    longint x0;
    longint x1;
    int     ph;
    int     dout;
    int     err;
  } vec_t;

  vec_t vecs [12];
  int   n_checks = 0;
  int   n_err    = 0;
  bit   pat [10] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

  function automatic longint sc(input int v);
    return longint'(v) <<< SH;
  endfunction

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic longint dout_s();
    return longint'($signed(o_dout));
  endfunction

  task automatic drive_beat(input longint x0, input longint x1, input int ph);
    i_dtin      = {x1[DW-1:0], x0[DW-1:0]};
    i_sym_phase = 1'(ph);
    i_vldin     = 1'b1;
  endtask

  // Back-to-back beats; the first nbig carry x=0 (|e| = R, a big error).
  task automatic stream(input int n, input int nbig, input longint xv);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      drive_beat((i < nbig) ? 64'sd0 : xv, 64'sd0, 0);
    end
    @(negedge clk);
    i_vldin = 1'b0;
  endtask

  task automatic wait_neg(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  initial begin
    int strobes;

    vecs[0]  = '{sc(4096),               0,        0, 4096,   0};
    vecs[1]  = '{sc(5000),               0,        0, 5000,   1};
    vecs[2]  = '{-sc(3000),              0,        0, -3000,  1};
    vecs[3]  = '{0,                      0,        0, 0,      0};
    vecs[4]  = '{(64'sd1 <<< 35) - 1,    0,        0, 32767,  1};
    vecs[5]  = '{-(64'sd1 <<< 35),       0,        0, -32767, 0};
    vecs[6]  = '{64'sd1 <<< 17,          0,        0, 1,      0};
    vecs[7]  = '{0,                      sc(100),  1, 100,    0};
    vecs[8]  = '{-(64'sd1 <<< 17),       0,        0, 0,      0};
    vecs[9]  = '{-(64'sd1 <<< 17) - 1,   0,        0, -1,     1};
    vecs[10] = '{sc(2000),               0,        0, 2000,   0};
    vecs[11] = '{-sc(6000),              sc(7),    0, -6000,  0};

    reset        = 1'b1;
    i_dtin       = '0;
    i_vldin      = 1'b0;
    i_sym_phase  = 1'b0;
    i_ref_level  = 16'd4096;
    i_lock_thr   = 11'd10;
    i_unlock_thr = 11'd200;

    wait_neg(3);
    check("reset_dout",    dout_s(), 0);
    check("reset_symvld",  o_sym_vld, 0);
    check("reset_error",   o_error, 0);
    check("reset_lock",    o_lock, 0);
    check("reset_errcnt",  o_err_cnt, 0);
    reset = 1'b0;
    wait_neg(2);

    // Single symbols: strobe exactly 3 cycles after the beat, then hold.
    for (int v = 0; v < 12; v++) begin
      @(negedge clk);
      drive_beat(vecs[v].x0, vecs[v].x1, vecs[v].ph);
      @(negedge clk);
      i_vldin = 1'b0;
      check($sformatf("v%0d_vld_t1", v), o_sym_vld, 0);
      @(negedge clk);
      check($sformatf("v%0d_vld_t2", v), o_sym_vld, 0);
      @(negedge clk);
      check($sformatf("v%0d_vld_t3", v), o_sym_vld, 1);
      check($sformatf("v%0d_dout", v),   dout_s(), vecs[v].dout);
      check($sformatf("v%0d_error", v),  o_error, vecs[v].err);
      @(negedge clk);
      check($sformatf("v%0d_vld_t4", v),  o_sym_vld, 0);
      check($sformatf("v%0d_dout_hold", v), dout_s(), vecs[v].dout);
      check($sformatf("v%0d_err_hold", v),  o_error, vecs[v].err);
    end

    // Phase switch between back-to-back beats; in-flight symbol keeps phase 0.
    @(negedge clk);
    drive_beat(sc(10), sc(20), 0);
    @(negedge clk);
    drive_beat(sc(10), sc(20), 1);
    @(negedge clk);
    drive_beat(sc(30), sc(40), 0);
    i_vldin = 1'b0;
    @(negedge clk);
    check("phsw_vld0",  o_sym_vld, 1);
    check("phsw_dout0", dout_s(), 10);
    @(negedge clk);
    check("phsw_vld1",  o_sym_vld, 1);
    check("phsw_dout1", dout_s(), 20);
    @(negedge clk);
    check("phsw_vld2",  o_sym_vld, 0);
    wait_neg(3);

    // Gapped valids: beats at i=0,2,3 only -> three strobes, last value 28.
    strobes = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (o_sym_vld) strobes++;
      drive_beat(sc((i + 1) * 7), 64'sd0, 0);
      i_vldin = pat[i];
    end
    check("gap_strobes", strobes, 3);
    check("gap_last",    dout_s(), 28);

    // Start lock tests on a fresh window.
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    wait_neg(2);

    // Window 1: all clean -> lock one cycle after the 1024th strobe.
    stream(1024, 0, sc(4096));
    wait_neg(2);
    check("w1_last_strobe", o_sym_vld, 1);
    check("w1_lock_early",  o_lock, 0);
    @(negedge clk);
    check("w1_lock",   o_lock, 1);
    check("w1_errcnt", o_err_cnt, 0);

    // Window 2: 300 big errors -> unlock.
    stream(1024, 300, sc(4096));
    wait_neg(2);
    check("w2_lock_hold", o_lock, 1);
    @(negedge clk);
    check("w2_lock",   o_lock, 0);
    check("w2_errcnt", o_err_cnt, 300);

    // Window 3: 5 big errors (<= 10) -> lock again.
    stream(1024, 5, sc(4096));
    wait_neg(3);
    check("w3_lock",   o_lock, 1);
    check("w3_errcnt", o_err_cnt, 5);

    // Partial window of 500, then asynchronous reset with symbols in flight.
    stream(500, 0, sc(5000));
    check("pre_rst_dout",  dout_s(), 5000);
    check("pre_rst_error", o_error, 1);
    check("pre_rst_vld",   o_sym_vld, 1);
    #1 reset = 1'b1;
    #1;
    check("arst_dout",   dout_s(), 0);
    check("arst_symvld", o_sym_vld, 0);
    check("arst_error",  o_error, 0);
    check("arst_lock",   o_lock, 0);
    check("arst_errcnt", o_err_cnt, 0);
    @(negedge clk);
    reset = 1'b0;
    wait_neg(2);
    check("post_rst_flush", o_sym_vld, 0);

    // 1023 post-reset symbols: no decision yet.
    stream(1023, 0, sc(4096));
    wait_neg(5);
    check("post_rst_1023_lock", o_lock, 0);
    check("post_rst_1023_cnt",  o_err_cnt, 0);
    stream(1, 0, sc(4096));
    wait_neg(2);
    check("post_rst_1024_vld",  o_sym_vld, 1);
    check("post_rst_1024_pre",  o_lock, 0);
    @(negedge clk);
    check("post_rst_1024_lock", o_lock, 1);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
